// File: rtl/layer_sequencer.sv
// Sequences one shared Layer datapath through NUM_LAYERS passes of a small MLP.
// Latency: out_valid rises NUM_LAYERS*(PIPE_LAT+2) cycles after the input is accepted.
// Backpressure: one inference in flight; in_ready stays low until the output is taken via out_ready.
module layer_sequencer #(
  parameter int MAX_N      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LAYERS = 2,
  parameter int PIPE_LAT   = 2,
  parameter logic [(NUM_LAYERS+1)*8-1:0] LAYER_SIZES = {8'd4, 8'd8, 8'd4},
  parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_N*DATA_WIDTH-1:0] in_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAX_N*DATA_WIDTH-1:0] out_vec,
  output logic [LW-1:0]               param_addr,
  output logic                        param_en,
  output logic [MAX_N*DATA_WIDTH-1:0] lyr_in_vec,
  input  logic [MAX_N*DATA_WIDTH-1:0] lyr_out_vec,
  output logic                        busy,
  output logic [LW-1:0]               layer_idx
);

  localparam int VW = MAX_N * DATA_WIDTH;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  logic [VW-1:0]   act;
  logic [CW-1:0]   cnt;

  // Lane-keep masks are elaboration-time constants: one for the host input,
  // one per layer output (entry k masks to LAYER_SIZES entry k+1).
  logic [VW-1:0]   in_mask;
  logic [VW-1:0]   out_mask [NUM_LAYERS];

  for (genvar i = 0; i < MAX_N; i++) begin : g_in_mask
    assign in_mask[i*DATA_WIDTH +: DATA_WIDTH] =
      (i < int'(LAYER_SIZES[7:0])) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    for (genvar i = 0; i < MAX_N; i++) begin : g_lane
      assign out_mask[k][i*DATA_WIDTH +: DATA_WIDTH] =
        (i < int'(LAYER_SIZES[(k+1)*8 +: 8])) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
  end

  // The Layer always sees the activation register; the host sees it only while DONE.
  assign lyr_in_vec = act;
  assign out_vec    = out_valid ? act : '0;

  // Control FSM; every handshake/status output is a registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      act        <= '0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      param_en   <= 1'b0;
      param_addr <= '0;
      busy       <= 1'b0;
      layer_idx  <= '0;
    end else begin
      param_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            act        <= in_vec & in_mask;
            layer_idx  <= '0;
            param_addr <= '0;
            param_en   <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Parameter data and lyr_in_vec are both stable here; just wait out the pipe.
          cnt <= cnt + 1'b1;
          if (cnt == CW'(PIPE_LAT - 1)) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          act <= lyr_out_vec & out_mask[layer_idx];
          if (layer_idx == LW'(NUM_LAYERS - 1)) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            layer_idx  <= layer_idx + 1'b1;
            param_addr <= layer_idx + 1'b1;
            param_en   <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            layer_idx <= '0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: parameter ROM + 2-stage Layer model around the DUT.
// Table vectors, hand-written corner sequences, then random weights checked against a reference MLP.
module tb_layer_sequencer;
  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_vec;
  logic [0:0]    param_addr;
  logic          param_en;
  logic [VW-1:0] lyr_in_vec;
  logic [VW-1:0] lyr_out_vec;
  logic          busy;
  logic [0:0]    layer_idx;

  int vectors = 0;
  int miscompares = 0;

  int w [2][8][8];
  int b [2][8];
  int sizes [3] = '{4, 8, 4};

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .param_addr(param_addr), .param_en(param_en),
    .lyr_in_vec(lyr_in_vec), .lyr_out_vec(lyr_out_vec),
    .busy(busy), .layer_idx(layer_idx)
  );

  // ---------------- environment: parameter ROM + Layer pipeline ----------------
  logic [0:0]    rd_l = '0;
  logic [VW-1:0] s1 = '0, s2 = '0;

  function automatic logic [VW-1:0] layer_fn(input logic [VW-1:0] x, input int l);
    logic [VW-1:0] r;
    int acc;
    r = '0;
    for (int o = 0; o < 8; o++) begin
      acc = b[l][o];
      for (int i = 0; i < 8; i++) acc += w[l][o][i] * int'($signed(x[i*8 +: 8]));
      r[o*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (param_en) rd_l <= param_addr;
    s1 <= layer_fn(lyr_in_vec, int'(rd_l));
    s2 <= s1;
  end
  assign lyr_out_vec = s2;

  // ---------------- monitors ----------------
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, pe_cnt = 0;
  int pe_cyc [$];
  int pe_addr [$];
  int ho_cyc [$];
  logic [VW-1:0] ho_vec [$];
  logic [VW-1:0] mid_vec = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      acc_cyc <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (param_en) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc.push_back(cyc);
      pe_addr.push_back(int'(param_addr));
      if (param_addr == 1'b1) mid_vec <= lyr_in_vec;
    end
    if (out_valid && out_ready) begin
      ho_cyc.push_back(cyc);
      ho_vec.push_back(out_vec);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out, got no event, required one within 200 cycles", nm);
  endtask

  function automatic logic [VW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a [8];
    logic [VW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  // Plain-arithmetic MLP: mask input, then for each layer y = Wx + b wrapped to 8 bits,
  // with lanes beyond that layer's width forced to zero.
  function automatic logic [VW-1:0] ref_model(input logic [VW-1:0] v);
    int x [8];
    int y [8];
    int acc;
    logic [VW-1:0] r;
    for (int i = 0; i < 8; i++) x[i] = (i < sizes[0]) ? int'($signed(v[i*8 +: 8])) : 0;
    for (int l = 0; l < 2; l++) begin
      for (int o = 0; o < 8; o++) begin
        acc = b[l][o];
        for (int i = 0; i < 8; i++) acc += w[l][o][i] * x[i];
        y[o] = (o < sizes[l+1]) ? int'(byte'(acc)) : 0;
      end
      x = y;
    end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(x[i]);
    return r;
  endfunction

  task automatic set_cfg(input int c);
    for (int l = 0; l < 2; l++)
      for (int o = 0; o < 8; o++) begin
        b[l][o] = 0;
        for (int i = 0; i < 8; i++) w[l][o][i] = 0;
      end
    case (c)
      0: for (int o = 0; o < 8; o++) begin w[0][o][o] = 1; w[1][o][o] = 1; end
      1: for (int o = 0; o < 8; o++) begin w[0][o][o] = 1; b[0][o] = 5; w[1][o][o] = 1; end
      2: for (int o = 0; o < 8; o++) begin w[0][o][o] = 2; w[1][o][o] = 1; b[1][o] = -1; end
      3: begin
        for (int o = 0; o < 8; o++) w[0][o][7-o] = 1;
        for (int o = 0; o < 4; o++) w[1][o][o+4] = 1;
      end
      default:
        for (int l = 0; l < 2; l++)
          for (int o = 0; o < 8; o++) begin
            b[l][o] = int'($urandom_range(15, 0)) - 8;
            for (int i = 0; i < 8; i++) w[l][o][i] = int'($urandom_range(6, 0)) - 3;
          end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [VW-1:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) fail_to("send_in_ready");
    in_vec = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, reports latency from the accepting edge, completes the handshake.
  task automatic recv(output logic [VW-1:0] got, output int lat);
    int t;
    t = 0;
    got = '0;
    lat = -1;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) begin
      fail_to("recv_out_valid");
      return;
    end
    lat = cyc - acc_cyc - 1;
    got = out_vec;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int            cfg;
    logic [VW-1:0] vin;
    logic [VW-1:0] vmid;
    logic [VW-1:0] vexp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [VW-1:0] got, v0, exp;
    logic [VW-1:0] bb [3];
    int lat, t, a0, sent;

    tbl[0] = '{0, pk(1, 2, 3, 4, 9, 9, 9, 9),       pk(1, 2, 3, 4, 0, 0, 0, 0),      pk(1, 2, 3, 4, 0, 0, 0, 0)};
    tbl[1] = '{1, pk(1, 2, 3, 4, 9, 9, 9, 9),       pk(6, 7, 8, 9, 5, 5, 5, 5),      pk(6, 7, 8, 9, 0, 0, 0, 0)};
    tbl[2] = '{2, pk(-3, 0, 100, 7, 1, 1, 1, 1),    pk(-6, 0, -56, 14, 0, 0, 0, 0),  pk(-7, -1, -57, 13, 0, 0, 0, 0)};
    tbl[3] = '{3, pk(10, 20, 30, 40, 1, 1, 1, 1),   pk(0, 0, 0, 0, 40, 30, 20, 10),  pk(40, 30, 20, 10, 0, 0, 0, 0)};

    // ---- reset / idle ----
    set_cfg(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_vec", out_vec, 0);
    chk("idle_layer_idx", layer_idx, 0);
    chk("idle_param_en_count", pe_cnt, 0);

    // ---- table: single inferences with known weights ----
    for (int k = 0; k < 4; k++) begin
      set_cfg(tbl[k].cfg);
      pe_cyc.delete();
      pe_addr.delete();
      send(tbl[k].vin);
      recv(got, lat);
      chk($sformatf("tbl%0d_out_vec", k), got, tbl[k].vexp);
      chk($sformatf("tbl%0d_latency", k), lat, 8);
      chk($sformatf("tbl%0d_mid_act", k), mid_vec, tbl[k].vmid);
      chk($sformatf("tbl%0d_post_out_valid", k), out_valid, 0);
      chk($sformatf("tbl%0d_post_in_ready", k), in_ready, 1);
      chk($sformatf("tbl%0d_post_layer_idx", k), layer_idx, 0);
      chk($sformatf("tbl%0d_pe_count", k), pe_cyc.size(), 2);
      if (pe_cyc.size() == 2) begin
        chk($sformatf("tbl%0d_pe_addr0", k), pe_addr[0], 0);
        chk($sformatf("tbl%0d_pe_addr1", k), pe_addr[1], 1);
        chk($sformatf("tbl%0d_pe_spacing", k), pe_cyc[1] - pe_cyc[0], 4);
      end
    end

    // ---- output backpressure ----
    set_cfg(0);
    send(pk(5, 6, 7, 8, 3, 3, 3, 3));
    t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) fail_to("bp_out_valid");
    v0 = out_vec;
    chk("bp_out_vec", v0, pk(5, 6, 7, 8, 0, 0, 0, 0));
    a0 = acc_cnt;
    in_vec = pk(11, 12, 13, 14, 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_vec", i), out_vec, v0);
      chk($sformatf("bp_hold%0d_valid", i), out_valid, 1);
      chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
    end
    chk("bp_no_accept", acc_cnt, a0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accepted", acc_cnt, a0 + 1);
    chk("bp_next_busy", busy, 1);
    recv(got, lat);
    chk("bp_next_out_vec", got, pk(11, 12, 13, 14, 0, 0, 0, 0));
    chk("bp_next_latency", lat, 8);

    // ---- reset in the middle of layer 1 ----
    set_cfg(1);
    send(pk(1, 2, 3, 4, 9, 9, 9, 9));
    repeat (5) @(negedge clk);
    chk("mid_layer_idx", layer_idx, 1);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_vec", out_vec, 0);
    chk("mid_rst_param_en", param_en, 0);
    chk("mid_rst_param_addr", param_addr, 0);
    chk("mid_rst_layer_idx", layer_idx, 0);
    chk("mid_rst_act", lyr_in_vec, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_cfg(2);
    exp = ref_model(pk(-3, 0, 100, 7, 1, 1, 1, 1));
    send(pk(-3, 0, 100, 7, 1, 1, 1, 1));
    recv(got, lat);
    chk("post_rst_out_vec", got, exp);
    chk("post_rst_latency", lat, 8);

    // ---- back-to-back with in_valid and out_ready held high ----
    set_cfg(0);
    bb[0] = pk(1, 1, 1, 1, 7, 7, 7, 7);
    bb[1] = pk(2, -2, 2, -2, 7, 7, 7, 7);
    bb[2] = pk(127, -128, 0, 3, 7, 7, 7, 7);
    ho_cyc.delete();
    ho_vec.delete();
    a0 = acc_cnt;
    out_ready = 1'b1;
    t = 0;
    while (ho_cyc.size() < 3 && t < 200) begin
      sent = acc_cnt - a0;
      in_valid = (sent < 3);
      if (sent < 3) in_vec = bb[sent];
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", ho_cyc.size(), 3);
    if (ho_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        bb[k][63:32] = '0;
        chk($sformatf("b2b%0d_vec", k), ho_vec[k], bb[k]);
      end
      chk("b2b_spacing1", ho_cyc[1] - ho_cyc[0], 10);
      chk("b2b_spacing2", ho_cyc[2] - ho_cyc[1], 10);
    end
    @(negedge clk);

    // ---- random weights and inputs against the reference MLP ----
    for (int k = 0; k < 8; k++) begin
      set_cfg(99);
      v0 = {$urandom, $urandom};
      exp = ref_model(v0);
      send(v0);
      recv(got, lat);
      chk($sformatf("rnd%0d_out_vec", k), got, exp);
      chk($sformatf("rnd%0d_latency", k), lat, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary, required completion within 20000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Time-multiplexes one shared Layer datapath instance across NUM_LAYERS fully-connected layers of a small MLP. Default topology is 4 -> 8 -> 4.
- Accepts an input activation vector through a valid/ready handshake.
- For each layer in turn, the block:
  - fetches that layer's weights and biases from an external synchronous parameter memory;
  - drives the Layer pipeline and waits out its latency;
  - captures the result and feeds it back as the next layer's input.
- Presents the final layer's activation through a valid/ready output handshake.
- Sits between the host-side stream and the Layer/parameter-ROM pair.

Parameters:
- MAX_N, 8, lane count of all vectors; width of the shared Layer (IN_N = OUT_N = MAX_N).
- DATA_WIDTH, 8, signed bits per activation lane.
- NUM_LAYERS, 2, number of layer passes per inference.
- PIPE_LAT, 2, Layer pipeline latency in cycles from in_vec to out_vec.
- LAYER_SIZES, {8'd4, 8'd8, 8'd4}, packed sizes.
  - Entry 0 is the input width.
  - Entry k+1 is the output width of layer k.
  - Every entry must be <= MAX_N.
- LW, $clog2(NUM_LAYERS) (minimum 1), width of the layer index.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, host input vector valid.
- in_ready, output, 1, sequencer can accept an input vector.
- in_vec, input, MAX_N*DATA_WIDTH, host activations; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid, output, 1, final activation vector valid.
- out_ready, input, 1, host accepts the output vector.
- out_vec, output, MAX_N*DATA_WIDTH, final activations; lanes >= LAYER_SIZES[NUM_LAYERS] are zero.
- param_addr, output, LW, layer index presented to the parameter memory.
- param_en, output, 1, parameter memory read strobe; read data is valid the cycle after param_en.
- lyr_in_vec, output, MAX_N*DATA_WIDTH, drives Layer in_vec; equals the internal activation register.
- lyr_out_vec, input, MAX_N*DATA_WIDTH, Layer out_vec.
- busy, output, 1, high in every state except IDLE.
- layer_idx, output, LW, layer currently being processed; 0 in IDLE.

Weights and biases flow directly from the parameter memory to the Layer and are not routed through this block. The sequencer only addresses the memory and times the reads.

Behaviour:
- Reset (asynchronous, applies in any state, including mid-inference):
  - state = IDLE;
  - activation register cleared to 0;
  - in_ready = 1, out_valid = 0, out_vec = 0;
  - param_en = 0, param_addr = 0;
  - busy = 0, layer_idx = 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_vec into the activation register, zeroing lanes >= LAYER_SIZES[0].
  - Then set layer_idx = 0 and go to FETCH.
- State FETCH (1 cycle):
  - param_en = 1, param_addr = layer_idx.
  - Go to RUN with the cycle counter = 0.
- State RUN (PIPE_LAT cycles):
  - lyr_in_vec is held stable; parameter data is valid from the first RUN cycle.
  - The counter increments each cycle; on counter == PIPE_LAT-1, go to CAPTURE.
- State CAPTURE (1 cycle):
  - Activation register <= lyr_out_vec, with lanes >= LAYER_SIZES[layer_idx+1] forced to 0.
  - If layer_idx == NUM_LAYERS-1: go to DONE.
  - Otherwise: layer_idx += 1 and go to FETCH.
- State DONE:
  - out_valid = 1; out_vec = activation register.
  - On out_ready: out_valid falls next cycle and the block goes to IDLE.
  - While out_ready is low, out_vec and out_valid are held stable indefinitely.
- Latency: out_valid rises exactly NUM_LAYERS*(PIPE_LAT+2) cycles after the accepting edge. Defaults give 8 cycles.
- Throughput: one inference at a time.
  - in_ready = 0 in FETCH, RUN, CAPTURE and DONE; in_valid in those states is ignored.
  - A new input is first accepted the cycle after the DONE handshake.
- Registered outputs: in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- Wrap-around: layer_idx never exceeds NUM_LAYERS-1 and returns to 0 on entry to IDLE.
- NUM_LAYERS = 1: the FETCH -> RUN -> CAPTURE path runs once, then DONE.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles, then release with in_valid = 0 -> in_ready = 1, busy = 0, out_valid = 0, out_vec = 0, param_en never asserts.
- Single inference:
  - Stimulus: in_vec lanes = [1, 2, 3, 4, 9, 9, 9, 9]; identity weights, zero biases, model Layer with PIPE_LAT = 2.
  - Response: out_valid rises exactly 8 cycles after acceptance; out_vec = [1, 2, 3, 4, 0, 0, 0, 0] (upper input lanes masked).
  - Response: param_en pulses with param_addr 0 then 1, 4 cycles apart.
- Lane masking:
  - Stimulus: layer 0 identity with bias 5 on all 8 lanes; layer 1 identity with zero bias.
  - Response: after layer 0 the activation register = [6, 7, 8, 9, 5, 5, 5, 5]; out_vec = [6, 7, 8, 9, 0, 0, 0, 0].
- Output backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_vec stable, in_ready = 0, a concurrent in_valid is not accepted; on out_ready = 1, IDLE follows and the next input is accepted one cycle later.
- Reset mid-operation: assert rst_n = 0 during RUN of layer 1 -> all outputs take reset values immediately; after release, a fresh inference yields the correct result with no stale activations.
- Back-to-back: 3 inferences with in_valid held high and out_ready = 1 -> outputs appear in order, one per 10 cycles (8 latency + DONE + IDLE).
